// File: rtl/oflow_cr_score_board.sv
// Conflict-resolve score board: collects PE entries for a frame, launches and serves the CR FSM,
// then streams the resolved {id,score,fallback} entries row-major and clears itself.
module oflow_cr_score_board #(
  parameter  int NUM_PE    = 8,
  parameter  int NUM_ROWS  = 4,
  parameter  int SCORE_LEN = 16,
  parameter  int ID_LEN    = 12,
  localparam int ROW_LEN   = $clog2(NUM_ROWS + 1),
  localparam int PE_LEN    = $clog2(NUM_PE + 1)
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 wr_en,
  input  logic [ROW_LEN-1:0]   wr_row,
  input  logic [PE_LEN-1:0]    wr_pe,
  input  logic [SCORE_LEN-1:0] wr_score,
  input  logic [ID_LEN-1:0]    wr_id,
  output logic                 wr_ready,
  input  logic                 frame_done,
  output logic                 start_cr,
  input  logic                 done_cr,
  input  logic                 conflict_counter_th,
  input  logic [ROW_LEN-1:0]   row_sel,
  input  logic [PE_LEN-1:0]    pe_sel,
  output logic [SCORE_LEN-1:0] score_to_cr,
  output logic [ID_LEN-1:0]    id_to_cr,
  input  logic [ROW_LEN-1:0]   row_to_change,
  input  logic [PE_LEN-1:0]    pe_to_change,
  input  logic                 data_to_score_board,
  input  logic                 write_to_pointer,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ID_LEN-1:0]    res_id,
  output logic [SCORE_LEN-1:0] res_score,
  output logic                 res_fallback,
  output logic                 res_last,
  output logic                 cr_overflow
);

  localparam int TOTAL    = NUM_ROWS * NUM_PE;
  localparam int BEAT_LEN = $clog2(TOTAL);

  typedef enum logic [1:0] {COLLECT_ST, START_ST, WAIT_ST, RESULT_ST} state_t;

  state_t state, next_state;

  // Slots are stored flat, indexed row*NUM_PE+pe, so the result stream is a simple counter.
  logic [SCORE_LEN-1:0] score_mem [TOTAL];
  logic [ID_LEN-1:0]    id_mem    [TOTAL];
  logic                 fb_mem    [TOTAL];

  logic [BEAT_LEN-1:0]  beat;
  logic [BEAT_LEN-1:0]  next_beat;
  logic                 last_beat;
  logic                 wr_hit, ptr_hit, rd_hit, stream_done;
  logic [BEAT_LEN-1:0]  wr_idx, ptr_idx, rd_idx;

  function automatic logic [BEAT_LEN-1:0] slot_idx(input logic [ROW_LEN-1:0] row,
                                                   input logic [PE_LEN-1:0]  pe);
    return BEAT_LEN'(int'(row) * NUM_PE + int'(pe));
  endfunction

  function automatic logic in_range(input logic [ROW_LEN-1:0] row, input logic [PE_LEN-1:0] pe);
    return (row < ROW_LEN'(NUM_ROWS)) && (pe < PE_LEN'(NUM_PE));
  endfunction

  assign wr_idx      = slot_idx(wr_row, wr_pe);
  assign ptr_idx     = slot_idx(row_to_change, pe_to_change);
  assign rd_idx      = slot_idx(row_sel, pe_sel);
  assign wr_hit      = wr_en && (state == COLLECT_ST) && in_range(wr_row, wr_pe);
  assign ptr_hit     = write_to_pointer && (state == WAIT_ST) && in_range(row_to_change, pe_to_change);
  assign rd_hit      = in_range(row_sel, pe_sel);
  assign next_beat   = beat + BEAT_LEN'(1);
  assign last_beat   = (beat == BEAT_LEN'(TOTAL - 1));
  assign stream_done = (state == RESULT_ST) && res_ready && last_beat;

  // Out-of-range selects return 0/0, which the CR treats as end of data.
  assign score_to_cr = rd_hit ? score_mem[rd_idx] : '0;
  assign id_to_cr    = rd_hit ? id_mem[rd_idx]    : '0;

  assign start_cr = (state == START_ST);
  assign wr_ready = (state == COLLECT_ST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) state <= COLLECT_ST;
    else          state <= next_state;
  end

  // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      COLLECT_ST: if (frame_done) next_state = START_ST;
      START_ST:   next_state = WAIT_ST;
      WAIT_ST:    if (done_cr) next_state = RESULT_ST;
      RESULT_ST:  if (stream_done) next_state = COLLECT_ST;
      default:    next_state = COLLECT_ST;
    endcase
  end

  // NOTE: the slot array is reset because id 0 marks an empty slot; stale ids would leak into the next frame.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      for (int i = 0; i < TOTAL; i++) begin
        score_mem[i] <= '0;
        id_mem[i]    <= '0;
        fb_mem[i]    <= 1'b0;
      end
    end else if (stream_done) begin
      for (int i = 0; i < TOTAL; i++) begin
        score_mem[i] <= '0;
        id_mem[i]    <= '0;
        fb_mem[i]    <= 1'b0;
      end
    end else begin
      if (wr_hit) begin
        score_mem[wr_idx] <= wr_score;
        id_mem[wr_idx]    <= wr_id;
        fb_mem[wr_idx]    <= 1'b0;
      end
      if (ptr_hit) fb_mem[ptr_idx] <= data_to_score_board;
    end
  end

  // Result stream: beat 0 is loaded as done_cr is accepted; later beats load on each handshake.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      res_valid    <= 1'b0;
      res_last     <= 1'b0;
      res_id       <= '0;
      res_score    <= '0;
      res_fallback <= 1'b0;
      beat         <= '0;
      cr_overflow  <= 1'b0;
    end else begin
      unique case (state)
        START_ST: cr_overflow <= 1'b0;
        WAIT_ST: begin
          if (done_cr) begin
            cr_overflow  <= conflict_counter_th;
            res_valid    <= 1'b1;
            res_last     <= 1'b0;
            beat         <= '0;
            res_id       <= id_mem[0];
            res_score    <= score_mem[0];
            // A pointer write landing together with done_cr must still reach beat 0.
            res_fallback <= (ptr_hit && ptr_idx == '0) ? data_to_score_board : fb_mem[0];
          end
        end
        RESULT_ST: begin
          if (res_ready) begin
            if (last_beat) begin
              res_valid <= 1'b0;
              res_last  <= 1'b0;
              beat      <= '0;
            end else begin
              beat         <= next_beat;
              res_id       <= id_mem[next_beat];
              res_score    <= score_mem[next_beat];
              res_fallback <= fb_mem[next_beat];
              res_last     <= (next_beat == BEAT_LEN'(TOTAL - 1));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
